// File: rtl/even_parity_chk.sv
// Serial even-parity frame checker: DATA_W data bits MSB-first followed by one
// parity bit, with saturating frame and error counters.
module even_parity_chk #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_x,
    input  logic              i_valid,
    input  logic              i_sync,
    input  logic              i_clr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_perr,
    output logic [CNT_W-1:0]  o_frame_cnt,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [BCW-1:0]    cnt, cnt_n;
    logic              par, par_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n, perr_n;
    logic [CNT_W-1:0]  fcnt_n, ecnt_n;
    logic              done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            sh          <= '0;
            cnt         <= '0;
            par         <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_perr      <= 1'b0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            state       <= state_n;
            sh          <= sh_n;
            cnt         <= cnt_n;
            par         <= par_n;
            o_data      <= data_n;
            o_valid     <= valid_n;
            o_perr      <= perr_n;
            o_frame_cnt <= fcnt_n;
            o_err_cnt   <= ecnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        par_n   = par;
        data_n  = o_data;
        valid_n = 1'b0;
        perr_n  = o_perr;
        fcnt_n  = o_frame_cnt;
        ecnt_n  = o_err_cnt;
        done    = 1'b0;

        // A sync with a valid bit restarts the frame using that bit as data bit 0.
        if (i_valid && (i_sync || state == S_IDLE)) begin
            sh_n  = DATA_W'(i_x);
            par_n = i_x;
            if (DATA_W == 1) begin
                state_n = S_PAR;
                cnt_n   = '0;
            end else begin
                state_n = S_DATA;
                cnt_n   = BCW'(1);
            end
        end else if (i_valid) begin
            case (state)
                S_DATA: begin
                    sh_n  = DATA_W'({sh, i_x});
                    par_n = par ^ i_x;
                    if (cnt == BCW'(DATA_W - 1)) begin
                        state_n = S_PAR;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + BCW'(1);
                    end
                end
                S_PAR: begin
                    done    = 1'b1;
                    data_n  = sh;
                    perr_n  = par ^ i_x;
                    valid_n = 1'b1;
                    state_n = S_IDLE;
                    sh_n    = '0;
                    par_n   = 1'b0;
                    cnt_n   = '0;
                end
                default: state_n = S_IDLE;
            endcase
        end else if (i_sync) begin
            state_n = S_IDLE;
            sh_n    = '0;
            par_n   = 1'b0;
            cnt_n   = '0;
        end

        if (done) begin
            if (o_frame_cnt != '1)
                fcnt_n = o_frame_cnt + CNT_W'(1);
            if (perr_n && o_err_cnt != '1)
                ecnt_n = o_err_cnt + CNT_W'(1);
        end
        if (i_clr) begin
            fcnt_n = '0;
            ecnt_n = '0;
        end
    end

endmodule

// File: tb/tb_even_parity_chk.sv
// Self-checking bench for even_parity_chk: default build plus a CNT_W=2 build
// driven by the same serial stream, checked against a frame-level model.
module tb_even_parity_chk;

    localparam int DW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_x = 1'b0, i_valid = 1'b0, i_sync = 1'b0, i_clr = 1'b0;

    logic [DW-1:0] a_o_data, b_o_data;
    logic          a_o_valid, b_o_valid, a_o_perr, b_o_perr;
    logic [7:0]    a_o_frame_cnt, a_o_err_cnt;
    logic [1:0]    b_o_frame_cnt, b_o_err_cnt;

    always #5 clk = ~clk;

    even_parity_chk #(.DATA_W(DW), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .i_x(i_x), .i_valid(i_valid), .i_sync(i_sync),
        .i_clr(i_clr), .o_data(a_o_data), .o_valid(a_o_valid), .o_perr(a_o_perr),
        .o_frame_cnt(a_o_frame_cnt), .o_err_cnt(a_o_err_cnt)
    );

    even_parity_chk #(.DATA_W(DW), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .i_x(i_x), .i_valid(i_valid), .i_sync(i_sync),
        .i_clr(i_clr), .o_data(b_o_data), .o_valid(b_o_valid), .o_perr(b_o_perr),
        .o_frame_cnt(b_o_frame_cnt), .o_err_cnt(b_o_err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int vpulses = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: collect accepted bits, evaluate when DW+1 are in hand.
    int m_bits[DW+1];
    int m_n = 0;
    int m_data = 0, m_perr = 0, m_valid = 0;
    int m_fa = 0, m_ea = 0, m_fb = 0, m_eb = 0;

    always @(posedge clk or posedge reset) begin : model
        int d, ones;
        if (reset) begin
            m_n = 0; m_data = 0; m_perr = 0; m_valid = 0;
            m_fa = 0; m_ea = 0; m_fb = 0; m_eb = 0;
        end else begin
            m_valid = 0;
            if (i_sync) m_n = 0;
            if (i_valid) begin
                m_bits[m_n] = int'(i_x);
                m_n++;
            end
            if (m_n == DW + 1) begin
                d = 0;
                ones = 0;
                for (int i = 0; i < DW; i++) d = d * 2 + m_bits[i];
                for (int i = 0; i <= DW; i++) ones += m_bits[i];
                m_data = d;
                m_perr = ones % 2;
                m_valid = 1;
                m_n = 0;
                m_fa = (m_fa < 255) ? m_fa + 1 : 255;
                m_fb = (m_fb < 3) ? m_fb + 1 : 3;
                if (m_perr == 1) begin
                    m_ea = (m_ea < 255) ? m_ea + 1 : 255;
                    m_eb = (m_eb < 3) ? m_eb + 1 : 3;
                end
            end
            if (i_clr) begin
                m_fa = 0; m_ea = 0; m_fb = 0; m_eb = 0;
            end
        end
    end

    always @(posedge clk) begin
        #3;
        if (a_o_valid) vpulses++;
        chk("cyc.a_valid", a_o_valid, m_valid);
        chk("cyc.a_data", a_o_data, m_data);
        chk("cyc.a_perr", a_o_perr, m_perr);
        chk("cyc.a_frame_cnt", a_o_frame_cnt, m_fa);
        chk("cyc.a_err_cnt", a_o_err_cnt, m_ea);
        chk("cyc.b_valid", b_o_valid, m_valid);
        chk("cyc.b_data", b_o_data, m_data);
        chk("cyc.b_perr", b_o_perr, m_perr);
        chk("cyc.b_frame_cnt", b_o_frame_cnt, m_fb);
        chk("cyc.b_err_cnt", b_o_err_cnt, m_eb);
    end

    task automatic send(input logic x, input int gap = 0, input logic sy = 1'b0, input logic cl = 1'b0);
        repeat (gap) begin
            @(negedge clk);
            i_valid = 1'b0; i_sync = 1'b0; i_clr = 1'b0;
        end
        @(negedge clk);
        i_valid = 1'b1; i_x = x; i_sync = sy; i_clr = cl;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0; i_sync = 1'b0; i_clr = 1'b0;
        end
    endtask

    task automatic frame(input logic [3:0] f);
        for (int i = 3; i >= 0; i--) send(f[i]);
    endtask

    task automatic lit(input string nm, input int d, input int p,
                       input int fa, input int ea, input int fb, input int eb);
        @(posedge clk);
        #3;
        chk({nm, ".valid"}, a_o_valid, 1);
        chk({nm, ".data"}, a_o_data, d);
        chk({nm, ".perr"}, a_o_perr, p);
        chk({nm, ".frame_cnt"}, a_o_frame_cnt, fa);
        chk({nm, ".err_cnt"}, a_o_err_cnt, ea);
        chk({nm, ".b_valid"}, b_o_valid, 1);
        chk({nm, ".b_frame_cnt"}, b_o_frame_cnt, fb);
        chk({nm, ".b_err_cnt"}, b_o_err_cnt, eb);
    endtask

    task automatic clr_pulse(input string nm);
        @(negedge clk);
        i_valid = 1'b0; i_sync = 1'b0; i_clr = 1'b1;
        @(posedge clk);
        #3;
        chk({nm, ".frame_cnt"}, a_o_frame_cnt, 0);
        chk({nm, ".err_cnt"}, a_o_err_cnt, 0);
        chk({nm, ".valid"}, a_o_valid, 0);
    endtask

    int v0;

    initial begin
        idle(2);
        @(negedge clk);
        reset = 1'b0;
        chk("rst.data", a_o_data, 0);
        chk("rst.valid", a_o_valid, 0);
        chk("rst.perr", a_o_perr, 0);
        chk("rst.frame_cnt", a_o_frame_cnt, 0);
        chk("rst.err_cnt", a_o_err_cnt, 0);

        // 1,0,1 parity 0
        frame(4'b1010);
        lit("basic", 5, 0, 1, 0, 1, 0);
        idle(1);
        @(posedge clk); #3;
        chk("basic.valid_drop", a_o_valid, 0);

        clr_pulse("clr1");
        frame(4'b1110);
        lit("err", 7, 1, 1, 1, 1, 1);
        frame(4'b0110);
        lit("ok_after_err", 3, 0, 2, 1, 2, 1);

        // gaps of 0..3 idle cycles between bits
        v0 = vpulses;
        send(1'b1, 2); send(1'b1, 0); send(1'b0, 3); send(1'b0, 1);
        lit("gaps", 6, 0, 3, 1, 3, 1);
        idle(3);
        chk("gaps.pulses", vpulses - v0, 1);

        // sync with a valid bit restarts the frame
        clr_pulse("clr2");
        v0 = vpulses;
        send(1'b1); send(1'b1); send(1'b0, 0, 1'b1); send(1'b1); send(1'b1); send(1'b0);
        lit("sync", 3, 0, 1, 0, 1, 0);
        idle(2);
        chk("sync.pulses", vpulses - v0, 1);

        // sync+valid while awaiting parity drops the pending frame
        send(1'b1); send(1'b0); send(1'b1); send(1'b1, 0, 1'b1); send(1'b0); send(1'b0); send(1'b1);
        lit("sync_par", 4, 0, 2, 0, 2, 0);

        // sync without a bit mid-frame
        send(1'b1); send(1'b1);
        @(negedge clk); i_valid = 1'b0; i_sync = 1'b1; i_clr = 1'b0;
        frame(4'b0000);
        lit("sync_only", 0, 0, 3, 0, 3, 0);

        // clear mid-frame leaves the frame intact
        send(1'b1); send(1'b0, 0, 1'b0, 1'b1); send(1'b1); send(1'b0);
        lit("clr_mid", 5, 0, 1, 0, 1, 0);

        for (int i = 0; i < 5; i++) frame(4'b1000);
        lit("sat2", 4, 1, 6, 5, 3, 3);

        // clear on the completing edge
        send(1'b1); send(1'b1); send(1'b0); send(1'b1, 0, 1'b0, 1'b1);
        lit("clr_done", 6, 1, 0, 0, 0, 0);

        for (int i = 0; i < 260; i++) frame(4'b0001);
        lit("sat8", 0, 1, 255, 255, 3, 3);

        // reset mid-frame
        send(1'b1); send(1'b1);
        @(negedge clk); i_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #3;
        chk("rst_mid.frame_cnt", a_o_frame_cnt, 0);
        chk("rst_mid.data", a_o_data, 0);
        @(negedge clk); reset = 1'b0;
        frame(4'b0011);
        lit("after_rst", 1, 0, 1, 0, 1, 0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
